vec_exec_stage: RTL and testbench
=================================

// Module: vec_exec_stage
// PURPOSE
// Decode-plus-execute slice of the 6-lane x 8-bit vector CPU.
// - Decodes the 7-bit instruction ID field into pipeline control signals.
// - Runs one SIMD ALU operation across all lanes and computes the 32-bit memory address.
// - Sits between the ID/EX and EX/MEM pipeline registers; all outputs are registered (1-cycle latency).
// PARAMETERS
// I  32  instruction/address width
// N  8   lane width (bits)
// R  6   number of lanes
// PORTS
// clk         in   1      clock, rising edge
// reset       in   1      synchronous, active-high
// Id          in   7      instr[31:25] = {type[1:0], op[2:0], IS[1:0]}
// SrcA        in   R*N    vector operand A, packed [R-1:0][N-1:0]
// SrcB        in   R*N    vector operand B
// SrcBi       in   4      register index of operand B
// Imm         in   N      immediate, instr[16:9]
// RegWrite    out  1      write register file in WB
// MemtoReg    out  1      WB selects memory data
// MemWrite    out  1      store to data memory
// FlagsWrite  out  1      commit ALUFlags in WB
// RegSrc      out  1      1: read port 2 uses instr[24:21]; 0: uses instr[16:13]
// VSIFlag     out  2      [1] immediate operand, [0] scalar mode
// ALUControl  out  3      ALU opcode
// ALUFlags    out  2      [1]=Z, [0]=C
// ALUOutput   out  R*N    lane results
// Address     out  I      effective memory address
// BEHAVIOUR
// - All outputs are flops: values captured at the rising edge from the current-cycle inputs.
// - A reset edge drives every output to 0, including the vectors and Address.
// - Reset has priority over a simultaneous valid input.
// - Decode by type, Id[6:5]:
//   - 00 data reg-reg: RegWrite=1, FlagsWrite=1, MemtoReg=0, MemWrite=0, RegSrc=0, VSIFlag=IS, ALUControl=op.
//   - 01 data reg-imm: same as 00, except VSIFlag={1,IS[0]}.
//   - 10 memory: op bit Id[4], S bit Id[3]; ALUControl=000; VSIFlag={0,S}; FlagsWrite=0.
//     - LD (Id[4]=0): RegWrite=1, MemtoReg=1, MemWrite=0, RegSrc=0.
//     - ST (Id[4]=1): RegWrite=0, MemtoReg=0, MemWrite=1, RegSrc=1.
//   - 11 control: all control outputs 0 (branching is handled outside this block).
// - Operand B selection, by priority:
//   - VSIFlag[1]=1: Imm broadcast to all lanes.
//   - else VSIFlag[0]=1: SrcB lane 0 broadcast to all lanes.
//   - else SrcB per lane.
//   - SrcBi==0 (R0 hardwired zero) forces B=0 whenever VSIFlag[1]=0.
// - ALUControl operations, per lane, modulo 2^N:
//   - 000 add, 001 sub (A-B), 010 and, 011 or, 100 xor.
//   - 101 shl by B[2:0], 110 logical shr by B[2:0], 111 mul (low N bits).
// - Flags:
//   - Z=1 iff all R lanes of the result are 0.
//   - C = OR over lanes of carry-out (add) or borrow (sub); 0 for all other operations.
// - Address = {SrcA[3],SrcA[2],SrcA[1],SrcA[0]} + zero-extended Imm, wraps mod 2^32.
// - Address is computed for every instruction; ALUOutput is computed for memory-type instructions too (no gating).
// - Unknown or undefined encodings do not exist: all 128 Id values decode deterministically.
// STRUCTURE
// - Shared package vec_pkg holds:
//   - I, N, R
//   - typedef lane_t = logic [N-1:0]
//   - typedef vec_t = lane_t [R-1:0]
//   - enum type_e {DATA_RR, DATA_RI, MEM, CTRL}
//   - enum alu_op_e {ADD, SUB, AND, OR, XOR, SHL, SHR, MUL}
// - One sub-module, vec_lane_alu: a combinational single lane taking a, b, op and returning y and carry.
//   - Instantiate it R times with a generate loop.
// - Decode, operand mux, flag reduction, address adder and output registers live in vec_exec_stage.
// TESTING
// - Reset: assert reset for 1 edge with any inputs -> every output 0 on the next cycle.
// - Reg-imm add: Id=0b01_000_11, SrcA lanes all 7, Imm=5, SrcBi=3 -> next cycle:
//   - VSIFlag=11, RegWrite=1, FlagsWrite=1.
//   - ALUOutput all 12, ALUFlags=00.
// - Reg-reg sub: Id=0b00_001_00, A=B={1,2,3,4,5,6}, SrcBi=2 -> ALUOutput all 0, ALUFlags=10.
// - Sub borrow: A lane0=0, B lane0=1, other lanes equal -> lane0=255, C=1, Z=0.
// - LD: Id=0b10_0_0_000, SrcA lanes[3:0]={0x00,0x00,0x01,0x00}, Imm=4 -> next cycle:
//   - Address=0x104, RegWrite=1, MemtoReg=1, MemWrite=0, RegSrc=0, FlagsWrite=0.
// - ST with wrap: Id=0b10_1_0_000, SrcA lanes[3:0]=0xFF each, Imm=2 -> next cycle:
//   - Address=0x00000001, MemWrite=1, RegSrc=1, RegWrite=0.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared parameters and types for the 6-lane x 8-bit vector execute slice.
package vec_pkg;

  localparam int I = 32;
  localparam int N = 8;
  localparam int R = 6;

  typedef logic [N-1:0] lane_t;
  typedef lane_t [R-1:0] vec_t;

  typedef enum logic [1:0] {DATA_RR, DATA_RI, MEM, CTRL} type_e;
  typedef enum logic [2:0] {ADD, SUB, AND, OR, XOR, SHL, SHR, MUL} alu_op_e;

endpackage

// File: rtl/vec_exec_stage_if.sv
// ID/EX inputs and EX/MEM registered outputs of the vector execute slice.
interface vec_exec_stage_if;
  import vec_pkg::*;

  logic [6:0]   Id;
  vec_t         SrcA;
  vec_t         SrcB;
  logic [3:0]   SrcBi;
  lane_t        Imm;

  logic         RegWrite;
  logic         MemtoReg;
  logic         MemWrite;
  logic         FlagsWrite;
  logic         RegSrc;
  logic [1:0]   VSIFlag;
  logic [2:0]   ALUControl;
  logic [1:0]   ALUFlags;
  vec_t         ALUOutput;
  logic [I-1:0] Address;

  modport master (
    output Id, SrcA, SrcB, SrcBi, Imm,
    input  RegWrite, MemtoReg, MemWrite, FlagsWrite, RegSrc,
    input  VSIFlag, ALUControl, ALUFlags, ALUOutput, Address
  );

  modport slave (
    input  Id, SrcA, SrcB, SrcBi, Imm,
    output RegWrite, MemtoReg, MemWrite, FlagsWrite, RegSrc,
    output VSIFlag, ALUControl, ALUFlags, ALUOutput, Address
  );

endinterface

// File: rtl/vec_lane_alu.sv
// Combinational single-lane ALU; carry is carry-out for add, borrow for sub.
module vec_lane_alu
  import vec_pkg::*;
(
  input  lane_t   a,
  input  lane_t   b,
  input  alu_op_e op,
  output lane_t   y,
  output logic    carry
);

  logic [N:0] sum;
  logic [N:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op)
      ADD: begin
        y     = sum[N-1:0];
        carry = sum[N];
      end
      SUB: begin
        y     = diff[N-1:0];
        carry = diff[N];
      end
      AND:     y = a & b;
      OR:      y = a | b;
      XOR:     y = a ^ b;
      SHL:     y = a << b[2:0];
      SHR:     y = a >> b[2:0];
      MUL:     y = a * b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vec_exec_stage.sv
// Decode + SIMD execute slice between ID/EX and EX/MEM; every output is a flop.
module vec_exec_stage
  import vec_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  vec_exec_stage_if.slave  bus
);

  type_e        ty;
  logic         reg_write;
  logic         mem_to_reg;
  logic         mem_write;
  logic         flags_write;
  logic         reg_src;
  logic [1:0]   vsi;
  alu_op_e      alu_ctl;
  vec_t         b_vec;
  vec_t         y_vec;
  logic [R-1:0] carry_vec;
  logic [I-1:0] addr;

  assign ty = type_e'(bus.Id[6:5]);

  always_comb begin
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    mem_write   = 1'b0;
    flags_write = 1'b0;
    reg_src     = 1'b0;
    vsi         = 2'b00;
    alu_ctl     = ADD;
    case (ty)
      DATA_RR: begin
        reg_write   = 1'b1;
        flags_write = 1'b1;
        vsi         = bus.Id[1:0];
        alu_ctl     = alu_op_e'(bus.Id[4:2]);
      end
      DATA_RI: begin
        reg_write   = 1'b1;
        flags_write = 1'b1;
        vsi         = {1'b1, bus.Id[0]};
        alu_ctl     = alu_op_e'(bus.Id[4:2]);
      end
      MEM: begin
        vsi = {1'b0, bus.Id[3]};
        if (bus.Id[4]) begin
          mem_write = 1'b1;
          reg_src   = 1'b1;
        end else begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // R0 reads as zero, but an immediate operand is never suppressed by it.
  always_comb begin
    b_vec = '0;
    for (int r = 0; r < R; r++) begin
      if (vsi[1])
        b_vec[r] = bus.Imm;
      else if (bus.SrcBi == 4'd0)
        b_vec[r] = '0;
      else if (vsi[0])
        b_vec[r] = bus.SrcB[0];
      else
        b_vec[r] = bus.SrcB[r];
    end
  end

  for (genvar r = 0; r < R; r++) begin : g_lane
    vec_lane_alu u_alu (
      .a     (bus.SrcA[r]),
      .b     (b_vec[r]),
      .op    (alu_ctl),
      .y     (y_vec[r]),
      .carry (carry_vec[r])
    );
  end

  assign addr = bus.SrcA[3:0] + I'(bus.Imm);

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.RegWrite   <= 1'b0;
      bus.MemtoReg   <= 1'b0;
      bus.MemWrite   <= 1'b0;
      bus.FlagsWrite <= 1'b0;
      bus.RegSrc     <= 1'b0;
      bus.VSIFlag    <= 2'b00;
      bus.ALUControl <= 3'b000;
      bus.ALUFlags   <= 2'b00;
      bus.ALUOutput  <= '0;
      bus.Address    <= '0;
    end else begin
      bus.RegWrite   <= reg_write;
      bus.MemtoReg   <= mem_to_reg;
      bus.MemWrite   <= mem_write;
      bus.FlagsWrite <= flags_write;
      bus.RegSrc     <= reg_src;
      bus.VSIFlag    <= vsi;
      bus.ALUControl <= alu_ctl;
      bus.ALUFlags   <= {~|y_vec, |carry_vec};
      bus.ALUOutput  <= y_vec;
      bus.Address    <= addr;
    end
  end

endmodule

// File: tb/tb_vec_exec_stage.sv
// Directed-vector bench for vec_exec_stage with a behavioural reference model.
module tb_vec_exec_stage;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  vec_exec_stage_if bus ();

  vec_exec_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic        mw;
    logic        fw;
    logic        rs;
    logic [1:0]  vsi;
    logic [2:0]  alu;
    logic [1:0]  flags;
    logic [47:0] out;
    logic [31:0] addr;
  } exp_t;

  exp_t exp_q;
  logic exp_valid = 1'b0;

  function automatic exp_t model(input logic [6:0] id, input logic [47:0] a,
                                 input logic [47:0] b, input logic [3:0] bi,
                                 input logic [7:0] imm, input logic rst);
    exp_t       e;
    logic [1:0] t;
    logic [2:0] op;
    int         av;
    int         bv;
    int         res;
    logic       cy;
    e = '0;
    if (rst) return e;
    t  = id[6:5];
    op = id[4:2];
    if (t == 2'd0 || t == 2'd1) begin
      e.rw  = 1'b1;
      e.fw  = 1'b1;
      e.alu = op;
      e.vsi = (t == 2'd1) ? {1'b1, id[0]} : id[1:0];
    end else if (t == 2'd2) begin
      e.vsi = {1'b0, id[3]};
      if (id[4]) begin
        e.mw = 1'b1;
        e.rs = 1'b1;
      end else begin
        e.rw  = 1'b1;
        e.mtr = 1'b1;
      end
    end
    cy = 1'b0;
    for (int l = 0; l < 6; l++) begin
      av = int'(a[l*8 +: 8]);
      if (e.vsi[1])       bv = int'(imm);
      else if (bi == 4'd0) bv = 0;
      else if (e.vsi[0])  bv = int'(b[7:0]);
      else                bv = int'(b[l*8 +: 8]);
      case (e.alu)
        3'd0: begin res = av + bv; if (res > 255) cy = 1'b1; end
        3'd1: begin res = av - bv; if (res < 0)   cy = 1'b1; end
        3'd2: res = av & bv;
        3'd3: res = av | bv;
        3'd4: res = av ^ bv;
        3'd5: res = av << (bv % 8);
        3'd6: res = av >> (bv % 8);
        default: res = av * bv;
      endcase
      e.out[l*8 +: 8] = 8'(res);
    end
    e.flags = {(e.out == 48'd0), cy};
    e.addr  = a[31:0] + 32'(imm);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  always @(posedge clk) begin
    exp_q     <= model(bus.Id, bus.SrcA, bus.SrcB, bus.SrcBi, bus.Imm, reset);
    exp_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      chk("model.RegWrite",   64'(bus.RegWrite),   64'(exp_q.rw));
      chk("model.MemtoReg",   64'(bus.MemtoReg),   64'(exp_q.mtr));
      chk("model.MemWrite",   64'(bus.MemWrite),   64'(exp_q.mw));
      chk("model.FlagsWrite", 64'(bus.FlagsWrite), 64'(exp_q.fw));
      chk("model.RegSrc",     64'(bus.RegSrc),     64'(exp_q.rs));
      chk("model.VSIFlag",    64'(bus.VSIFlag),    64'(exp_q.vsi));
      chk("model.ALUControl", 64'(bus.ALUControl), 64'(exp_q.alu));
      chk("model.ALUFlags",   64'(bus.ALUFlags),   64'(exp_q.flags));
      chk("model.ALUOutput",  64'(bus.ALUOutput),  64'(exp_q.out));
      chk("model.Address",    64'(bus.Address),    64'(exp_q.addr));
    end
  end

  task automatic step(input logic [6:0] id, input logic [47:0] a, input logic [47:0] b,
                      input logic [3:0] bi, input logic [7:0] imm, input logic rst);
    bus.Id    = id;
    bus.SrcA  = a;
    bus.SrcB  = b;
    bus.SrcBi = bi;
    bus.Imm   = imm;
    reset     = rst;
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    bus.Id    = '0;
    bus.SrcA  = '0;
    bus.SrcB  = '0;
    bus.SrcBi = '0;
    bus.Imm   = '0;
    @(negedge clk);

    // reset with a live-looking instruction on the inputs
    step(7'b00_000_00, 48'hA5A5A5A5A5A5, 48'h5A5A5A5A5A5A, 4'd3, 8'h77, 1'b1);
    chk("rst.RegWrite",  64'(bus.RegWrite),  64'd0);
    chk("rst.ALUOutput", 64'(bus.ALUOutput), 64'd0);
    chk("rst.Address",   64'(bus.Address),   64'd0);

    step(7'b01_000_11, 48'h070707070707, 48'h123456789ABC, 4'd3, 8'd5, 1'b0);
    chk("radd.VSIFlag",    64'(bus.VSIFlag),    64'd3);
    chk("radd.RegWrite",   64'(bus.RegWrite),   64'd1);
    chk("radd.FlagsWrite", 64'(bus.FlagsWrite), 64'd1);
    chk("radd.ALUOutput",  64'(bus.ALUOutput),  64'h0C0C0C0C0C0C);
    chk("radd.ALUFlags",   64'(bus.ALUFlags),   64'd0);

    step(7'b00_001_00, 48'h010203040506, 48'h010203040506, 4'd2, 8'h00, 1'b0);
    chk("rsub.ALUOutput", 64'(bus.ALUOutput), 64'd0);
    chk("rsub.ALUFlags",  64'(bus.ALUFlags),  64'd2);

    step(7'b00_001_00, 48'h010203040500, 48'h010203040501, 4'd2, 8'h00, 1'b0);
    chk("borrow.ALUOutput", 64'(bus.ALUOutput), 64'h0000000000FF);
    chk("borrow.ALUFlags",  64'(bus.ALUFlags),  64'd1);

    step(7'b10_0_0_000, 48'h000000000100, 48'h0, 4'd1, 8'd4, 1'b0);
    chk("ld.Address",    64'(bus.Address),    64'h104);
    chk("ld.RegWrite",   64'(bus.RegWrite),   64'd1);
    chk("ld.MemtoReg",   64'(bus.MemtoReg),   64'd1);
    chk("ld.MemWrite",   64'(bus.MemWrite),   64'd0);
    chk("ld.RegSrc",     64'(bus.RegSrc),     64'd0);
    chk("ld.FlagsWrite", 64'(bus.FlagsWrite), 64'd0);

    step(7'b10_1_0_000, 48'h0000FFFFFFFF, 48'h0, 4'd5, 8'd2, 1'b0);
    chk("st.Address",  64'(bus.Address),  64'h1);
    chk("st.MemWrite", 64'(bus.MemWrite), 64'd1);
    chk("st.RegSrc",   64'(bus.RegSrc),   64'd1);
    chk("st.RegWrite", 64'(bus.RegWrite), 64'd0);

    step(7'b00_000_01, 48'h010101010101, 48'h777777777710, 4'd4, 8'h00, 1'b0);
    chk("scalar.ALUOutput", 64'(bus.ALUOutput), 64'h111111111111);
    chk("scalar.VSIFlag",   64'(bus.VSIFlag),   64'd1);

    step(7'b00_100_00, 48'h123456789ABC, 48'hFFFFFFFFFFFF, 4'd0, 8'h00, 1'b0);
    chk("r0zero.ALUOutput", 64'(bus.ALUOutput), 64'h123456789ABC);

    step(7'b01_111_10, 48'h101010101010, 48'h0, 4'd0, 8'h11, 1'b0);
    chk("imul.ALUOutput", 64'(bus.ALUOutput), 64'h101010101010);
    chk("imul.VSIFlag",   64'(bus.VSIFlag),   64'd2);

    step(7'b00_000_00, 48'h0000000000F0, 48'h000000000020, 4'd1, 8'h00, 1'b0);
    chk("carry.ALUOutput", 64'(bus.ALUOutput), 64'h000000000010);
    chk("carry.ALUFlags",  64'(bus.ALUFlags),  64'd1);

    step(7'b00_101_00, 48'h818181818181, 48'h010101010109, 4'd7, 8'h00, 1'b0);
    chk("shl.ALUOutput", 64'(bus.ALUOutput), 64'h020202020202);

    step(7'b00_110_00, 48'h808080808080, 48'h030303030303, 4'd7, 8'h00, 1'b0);
    chk("shr.ALUOutput", 64'(bus.ALUOutput), 64'h101010101010);

    step(7'b11_111_11, 48'h0102030405FF, 48'h0102030405FF, 4'd9, 8'h40, 1'b0);
    chk("ctrl.RegWrite",   64'(bus.RegWrite),   64'd0);
    chk("ctrl.ALUControl", 64'(bus.ALUControl), 64'd0);
    chk("ctrl.VSIFlag",    64'(bus.VSIFlag),    64'd0);

    // reset must win over a valid instruction on the same edge
    step(7'b00_000_00, 48'h010101010101, 48'h010101010101, 4'd1, 8'h00, 1'b1);
    chk("rstprio.ALUOutput", 64'(bus.ALUOutput), 64'd0);
    chk("rstprio.RegWrite",  64'(bus.RegWrite),  64'd0);

    for (int k = 0; k < 128; k++)
      step(7'(k), 48'h1F2E3D4CFB6A, 48'h0102F3048506, 4'(k), 8'hC5, 1'b0);

    step(7'b00_000_00, 48'h0, 48'h0, 4'd0, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
